// File: rtl/max_subtract_stream.sv
// Frame buffer for the softmax max-subtract stage: stores one frame, waits for
// the frame maximum, then streams saturated (Xmax - Xi) magnitudes with valid/ready.
module max_subtract_stream #(
  parameter int data_size      = 32,
  parameter int number_of_data = 10
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 data_valid_i,
  input  logic [data_size-1:0] data_i,
  output logic                 data_ready_o,
  input  logic                 max_valid_i,
  input  logic [data_size-1:0] data_max_i,
  output logic                 sub_valid_o,
  output logic [data_size-1:0] sub_data_o,
  output logic                 sub_last_o,
  input  logic                 sub_ready_i,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int ADDR_W = (number_of_data > 1) ? $clog2(number_of_data) : 1;
  localparam logic [7:0] LAST_IDX = 8'(number_of_data - 1);

  typedef enum logic [1:0] {
    LOAD     = 2'd0,
    WAIT_MAX = 2'd1,
    STREAM   = 2'd2
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [7:0]           wr_idx_q;
  logic [7:0]           rd_idx_q;
  logic [data_size-1:0] max_reg_q;
  logic [data_size-1:0] buffer_q [number_of_data];
  logic                 err_q;

  logic                 accept;
  logic                 transfer;
  logic                 wr_last;
  logic                 rd_last;
  logic [data_size-1:0] rd_sample;

  // Samples above the captured maximum clamp to zero distance instead of wrapping.
  function automatic logic [data_size-1:0] sat_sub(
    input logic [data_size-1:0] mx,
    input logic [data_size-1:0] x
  );
    if (x > mx) begin
      return '0;
    end
    return mx - x;
  endfunction

  function automatic logic exceeds(
    input logic [data_size-1:0] mx,
    input logic [data_size-1:0] x
  );
    return x > mx;
  endfunction

  assign rd_sample = buffer_q[rd_idx_q[ADDR_W-1:0]];
  assign wr_last   = (wr_idx_q == LAST_IDX);
  assign rd_last   = (rd_idx_q == LAST_IDX);
  assign accept    = data_valid_i && data_ready_o;
  assign transfer  = sub_valid_o && sub_ready_i;

  // State register
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD: begin
        if (accept && wr_last) begin
          state_d = WAIT_MAX;
        end
      end
      WAIT_MAX: begin
        if (max_valid_i) begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (transfer && rd_last) begin
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Output logic, all derived from registered state
  always_comb begin
    data_ready_o = 1'b0;
    sub_valid_o  = 1'b0;
    sub_last_o   = 1'b0;
    sub_data_o   = '0;
    case (state_q)
      LOAD: begin
        data_ready_o = 1'b1;
      end
      STREAM: begin
        sub_valid_o = 1'b1;
        sub_last_o  = rd_last;
        sub_data_o  = sat_sub(max_reg_q, rd_sample);
      end
      default: begin
        data_ready_o = 1'b0;
      end
    endcase
  end

  assign busy_o = (state_q != LOAD) || (wr_idx_q != 8'd0);
  assign err_o  = err_q;

  // Frame storage, indices, captured maximum and sticky error
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_idx_q  <= 8'd0;
      rd_idx_q  <= 8'd0;
      max_reg_q <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < number_of_data; i++) begin
        buffer_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        buffer_q[wr_idx_q[ADDR_W-1:0]] <= data_i;
        wr_idx_q <= wr_last ? 8'd0 : wr_idx_q + 8'd1;
      end
      if ((state_q == WAIT_MAX) && max_valid_i) begin
        max_reg_q <= data_max_i;
      end
      if (transfer) begin
        rd_idx_q <= rd_last ? 8'd0 : rd_idx_q + 8'd1;
        if (exceeds(max_reg_q, rd_sample)) begin
          err_q <= 1'b1;
        end
      end
    end
  end

endmodule
